iic_target_regs: RTL and testbench

I2C target (slave) with a small register file, clocked by `sys_clock`. It is the responder for the fabric's I2C controller on the `iic_scl_io`/`iic_sda_io` pins. It lets the processor write `ctrl_out` and `scratch`, and read back `status_in` and a fixed ID over the bus, for on-board loopback and pin-level bring-up. It sits beside the processor wrapper in the top level; the top level owns the open-drain IOBUFs.

---
 rtl/iic_target_regs_pkg.sv | 24 ++
 rtl/iic_bus_sync.sv | 46 ++++
 rtl/iic_target_regs.sv | 191 +++++++++++++++++++
 tb/tb_iic_target_regs.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iic_target_regs_pkg.sv
// Shared definitions for the I2C target register block: FSM states,
// register indices and synchronizer depth.
package iic_target_regs_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RACK
  } state_t;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_SCRATCH = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_ID      = 2'd3;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/iic_bus_sync.sv
// Pad synchronizers plus SCL edge and START/STOP detection for the I2C target.
module iic_bus_sync
  import iic_target_regs_pkg::*;
(
  input  logic sys_clock,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_pipe;
  logic [SYNC_STAGES-1:0] sda_pipe;
  logic                   scl_s;
  logic                   scl_d;
  logic                   sda_d;

  // Reset to the idle bus level so release never looks like an edge.
  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      scl_pipe <= '1;
      sda_pipe <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_pipe <= {scl_pipe[SYNC_STAGES-2:0], scl_i};
      sda_pipe <= {sda_pipe[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s    = scl_pipe[SYNC_STAGES-1];
  assign sda_s    = sda_pipe[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;

  // SCL must be high on both samples, so an SDA edge coincident with an SCL edge is data.
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/iic_target_regs.sv
// I2C target with a 4-entry register file: ctrl, scratch, status_in, ID.
// state | meaning: IDLE wait for START; ADDR/ADDR_ACK address byte; PTR/PTR_ACK pointer;
//   WDATA/WDATA_ACK write byte; RDATA/RACK read byte and master ACK/NACK.
module iic_target_regs
  import iic_target_regs_pkg::*;
#(
  parameter logic [6:0] TGT_ADDR = 7'h50,
  parameter logic [7:0] ID_VAL   = 8'hA5
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic [7:0] status_in,
  output logic [7:0] ctrl_out,
  output logic [7:0] scratch_out,
  output logic       wr_pulse,
  output logic [1:0] wr_idx,
  output logic       busy
);

  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic       sda_s;
  state_t     state;
  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic [1:0] ptr;
  logic       rw;
  logic       phase;
  logic [7:0] rx_byte;
  logic [7:0] rd_byte;

  iic_bus_sync u_sync (
    .sys_clock (sys_clock),
    .reset     (reset),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  assign rx_byte = {shift, sda_s};

  always_comb begin
    rd_byte = ID_VAL;
    case (ptr)
      REG_CTRL:    rd_byte = ctrl_out;
      REG_SCRATCH: rd_byte = scratch_out;
      REG_STATUS:  rd_byte = status_in;
      REG_ID:      rd_byte = ID_VAL;
      default:     rd_byte = ID_VAL;
    endcase
  end

  // phase marks the second half of an ACK slot: first SCL fall drives/releases, second ends it.
  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      bit_cnt     <= 3'd0;
      shift       <= 7'd0;
      ptr         <= 2'd0;
      rw          <= 1'b0;
      phase       <= 1'b0;
      sda_oe      <= 1'b0;
      ctrl_out    <= 8'd0;
      scratch_out <= 8'd0;
      wr_pulse    <= 1'b0;
      wr_idx      <= 2'd0;
      busy        <= 1'b0;
    end else begin
      wr_pulse <= 1'b0;
      if (start_det) begin
        state   <= ST_ADDR;
        bit_cnt <= 3'd0;
        phase   <= 1'b0;
        sda_oe  <= 1'b0;
        busy    <= 1'b1;
      end else if (stop_det) begin
        state  <= ST_IDLE;
        phase  <= 1'b0;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: if (scl_rise) begin
            shift   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (rx_byte[7:1] == TGT_ADDR) begin
                state <= ST_ADDR_ACK;
                rw    <= rx_byte[0];
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          ST_ADDR_ACK: if (scl_fall) begin
            if (!phase) begin
              sda_oe <= 1'b1;
              phase  <= 1'b1;
            end else begin
              phase   <= 1'b0;
              bit_cnt <= 3'd0;
              if (rw) begin
                shift  <= rd_byte[6:0];
                sda_oe <= ~rd_byte[7];
                state  <= ST_RDATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= ST_PTR;
              end
            end
          end
          ST_PTR: if (scl_rise) begin
            shift   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ptr   <= rx_byte[1:0];
              state <= ST_PTR_ACK;
            end
          end
          ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
            if (!phase) begin
              sda_oe <= 1'b1;
              phase  <= 1'b1;
            end else begin
              sda_oe  <= 1'b0;
              phase   <= 1'b0;
              bit_cnt <= 3'd0;
              state   <= ST_WDATA;
              if (state == ST_WDATA_ACK) ptr <= ptr + 2'd1;
            end
          end
          ST_WDATA: if (scl_rise) begin
            shift   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              wr_pulse <= 1'b1;
              wr_idx   <= ptr;
              if (ptr == REG_CTRL)    ctrl_out    <= rx_byte;
              if (ptr == REG_SCRATCH) scratch_out <= rx_byte;
              state <= ST_WDATA_ACK;
            end
          end
          ST_RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= ST_RACK;
                phase <= 1'b0;
              end
            end else if (scl_fall) begin
              sda_oe <= ~shift[6];
              shift  <= {shift[5:0], 1'b0};
            end
          end
          ST_RACK: begin
            if (scl_fall) begin
              if (!phase) begin
                sda_oe <= 1'b0;
                phase  <= 1'b1;
              end else begin
                shift   <= rd_byte[6:0];
                sda_oe  <= ~rd_byte[7];
                bit_cnt <= 3'd0;
                phase   <= 1'b0;
                state   <= ST_RDATA;
              end
            end else if (scl_rise && phase) begin
              if (sda_s) begin
                state <= ST_IDLE;
                phase <= 1'b0;
              end else begin
                ptr <= ptr + 2'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iic_target_regs.sv
// Bus-level bench for iic_target_regs: bit-banged I2C controller, write/read scoreboards,
// table-driven write transactions and hand-written corner sequences.
module tb_iic_target_regs;

  localparam int Q = 63;

  logic       sys_clock = 1'b0;
  logic       reset     = 1'b0;
  logic       scl_m     = 1'b1;
  logic       sda_m     = 1'b1;
  logic [7:0] status_in = 8'h00;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] ctrl_out;
  logic [7:0] scratch_out;
  logic       wr_pulse;
  logic [1:0] wr_idx;
  logic       busy;

  assign sda_bus = sda_m & ~sda_oe;

  iic_target_regs #(.TGT_ADDR(7'h50), .ID_VAL(8'hA5)) dut (
    .sys_clock   (sys_clock),
    .reset       (reset),
    .scl_i       (scl_m),
    .sda_i       (sda_bus),
    .sda_oe      (sda_oe),
    .status_in   (status_in),
    .ctrl_out    (ctrl_out),
    .scratch_out (scratch_out),
    .wr_pulse    (wr_pulse),
    .wr_idx      (wr_idx),
    .busy        (busy)
  );

  always #5 sys_clock = ~sys_clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write scoreboard: {idx, data} pushed before the data byte is driven.
  logic [9:0] wr_q[$];
  logic [9:0] wexp;
  always @(negedge sys_clock) begin
    if (reset && wr_pulse) begin
      if (wr_q.size() == 0) begin
        check("unexpected_wr_pulse", 32'(wr_idx), 32'hFFFF);
      end else begin
        wexp = wr_q.pop_front();
        check("wr_idx", 32'(wr_idx), 32'(wexp[9:8]));
        if (wexp[9:8] == 2'd0) check("wr_ctrl", 32'(ctrl_out), 32'(wexp[7:0]));
        if (wexp[9:8] == 2'd1) check("wr_scratch", 32'(scratch_out), 32'(wexp[7:0]));
      end
    end
  end

  logic watch_oe = 1'b0;
  logic oe_seen  = 1'b0;
  always @(negedge sys_clock) if (watch_oe && sda_oe) oe_seen = 1'b1;

  logic [7:0] rd_q[$];

  task automatic qwait();
    repeat (Q) @(negedge sys_clock);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b0; qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b1; qwait();
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    sda_m = b;    qwait();
    scl_m = 1'b1; qwait();
    r = sda_bus;  qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
    bit_xfer(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_check(input string name, input logic mack, input logic [7:0] exp);
    logic [7:0] d;
    logic [7:0] e;
    logic       r;
    rd_q.push_back(exp);
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      d[i] = r;
    end
    bit_xfer(~mack, r);
    e = rd_q.pop_front();
    check(name, 32'(d), 32'(e));
  endtask

  typedef struct {
    logic [7:0] ptr_byte;
    logic [7:0] data;
    logic [1:0] idx;
    logic [7:0] exp_ctrl;
    logic [7:0] exp_scratch;
  } vec_t;

  vec_t vecs[3];

  initial begin
    logic ack;
    logic r;

    vecs[0] = '{8'h00, 8'h3C, 2'd0, 8'h3C, 8'h00};
    vecs[1] = '{8'h05, 8'h77, 2'd1, 8'h3C, 8'h77};  // upper pointer bits ignored
    vecs[2] = '{8'h03, 8'h99, 2'd3, 8'h3C, 8'h77};

    repeat (5) @(negedge sys_clock);
    check("rst_sda_oe", 32'(sda_oe), 0);
    check("rst_ctrl", 32'(ctrl_out), 0);
    check("rst_scratch", 32'(scratch_out), 0);
    check("rst_wr_pulse", 32'(wr_pulse), 0);
    check("rst_busy", 32'(busy), 0);
    reset = 1'b1;
    repeat (5) @(negedge sys_clock);

    for (int i = 0; i < 3; i++) begin
      i2c_start();
      check("busy_after_start", 32'(busy), 1);
      write_byte(8'hA0, ack);
      check("tbl_addr_ack", 32'(ack), 1);
      write_byte(vecs[i].ptr_byte, ack);
      check("tbl_ptr_ack", 32'(ack), 1);
      wr_q.push_back({vecs[i].idx, vecs[i].data});
      write_byte(vecs[i].data, ack);
      check("tbl_data_ack", 32'(ack), 1);
      i2c_stop();
      check("tbl_busy_after_stop", 32'(busy), 0);
      check("tbl_ctrl", 32'(ctrl_out), 32'(vecs[i].exp_ctrl));
      check("tbl_scratch", 32'(scratch_out), 32'(vecs[i].exp_scratch));
    end

    // Auto-increment from scratch into read-only status
    i2c_start();
    write_byte(8'hA0, ack); check("inc_addr_ack", 32'(ack), 1);
    write_byte(8'h01, ack); check("inc_ptr_ack", 32'(ack), 1);
    wr_q.push_back({2'd1, 8'h11});
    write_byte(8'h11, ack); check("inc_d0_ack", 32'(ack), 1);
    wr_q.push_back({2'd2, 8'h22});
    write_byte(8'h22, ack); check("inc_d1_ack", 32'(ack), 1);
    i2c_stop();
    check("inc_scratch", 32'(scratch_out), 32'h11);
    check("inc_ctrl", 32'(ctrl_out), 32'h3C);

    // Combined-format read: status, ID, then wrap to ctrl
    status_in = 8'h5A;
    i2c_start();
    write_byte(8'hA0, ack); check("cr_addr_ack", 32'(ack), 1);
    write_byte(8'h02, ack); check("cr_ptr_ack", 32'(ack), 1);
    i2c_start();
    write_byte(8'hA1, ack); check("cr_raddr_ack", 32'(ack), 1);
    read_check("cr_rd_status", 1'b1, 8'h5A);
    read_check("cr_rd_id", 1'b1, 8'hA5);
    read_check("cr_rd_wrap_ctrl", 1'b0, 8'h3C);
    repeat (4) @(negedge sys_clock);
    check("cr_oe_after_nack", 32'(sda_oe), 0);
    i2c_stop();
    check("cr_busy_after_stop", 32'(busy), 0);

    // Wrong address: never drives SDA, nothing written
    watch_oe = 1'b1;
    oe_seen  = 1'b0;
    i2c_start();
    write_byte(8'hA2, ack); check("mis_addr_nack", 32'(ack), 0);
    write_byte(8'h00, ack); check("mis_byte_nack", 32'(ack), 0);
    i2c_stop();
    watch_oe = 1'b0;
    check("mis_oe_seen", 32'(oe_seen), 0);
    check("mis_ctrl", 32'(ctrl_out), 32'h3C);
    check("mis_busy", 32'(busy), 0);

    // STOP after 4 data bits discards the partial byte
    i2c_start();
    write_byte(8'hA0, ack); check("part_addr_ack", 32'(ack), 1);
    write_byte(8'h00, ack); check("part_ptr_ack", 32'(ack), 1);
    for (int i = 0; i < 4; i++) bit_xfer(1'b1, r);
    i2c_stop();
    check("part_ctrl", 32'(ctrl_out), 32'h3C);
    check("part_busy", 32'(busy), 0);

    // Reset while driving read data low
    status_in = 8'h00;
    i2c_start();
    write_byte(8'hA0, ack); check("rr_addr_ack", 32'(ack), 1);
    write_byte(8'h02, ack); check("rr_ptr_ack", 32'(ack), 1);
    i2c_start();
    write_byte(8'hA1, ack); check("rr_raddr_ack", 32'(ack), 1);
    check("rr_oe_driving", 32'(sda_oe), 1);
    reset = 1'b0;
    #1;
    check("rr_oe_cleared", 32'(sda_oe), 0);
    check("rr_ctrl", 32'(ctrl_out), 0);
    check("rr_scratch", 32'(scratch_out), 0);
    check("rr_wr_idx", 32'(wr_idx), 0);
    check("rr_busy", 32'(busy), 0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    qwait();
    reset = 1'b1;
    qwait();

    // Pointer back at 0 after reset, then a normal write
    i2c_start();
    write_byte(8'hA1, ack); check("pr_raddr_ack", 32'(ack), 1);
    read_check("pr_rd_ctrl", 1'b0, 8'h00);
    i2c_stop();
    i2c_start();
    write_byte(8'hA0, ack); check("pr_addr_ack", 32'(ack), 1);
    write_byte(8'h01, ack); check("pr_ptr_ack", 32'(ack), 1);
    wr_q.push_back({2'd1, 8'h5A});
    write_byte(8'h5A, ack); check("pr_data_ack", 32'(ack), 1);
    i2c_stop();
    check("pr_scratch", 32'(scratch_out), 32'h5A);
    check("wr_q_drained", 32'(wr_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
